uart_rx: RTL and testbench
==========================

// Module: uart_rx
// PURPOSE
//  Asynchronous serial receiver (8N1 by default), driven by the oversampling baud strobe from the baud divider
//  (OVERSAMPLE x baud rate). It synchronises rxd, detects and qualifies start bits, samples data bits at
//  mid-bit, checks the stop bit, and presents each byte through a one-entry valid/ready holding register.
//  Sits between the board rxd pin and the MMIO UART register block.
// PARAMETERS
//  OVERSAMPLE   4   baud_tick strobes per bit; even, >=4
//  DATA_BITS    8   data bits per frame, LSB first; 5..9
//  SYNC_STAGES  2   flip-flop stages on rxd; >=2
// PORTS
//  clk        in   1          system clock; all logic on posedge
//  rst        in   1          synchronous, active-high reset
//  baud_tick  in   1          1-cycle strobe at OVERSAMPLE x baud, synchronous to clk
//  rxd        in   1          asynchronous serial input, idle high
//  rx_data    out  DATA_BITS  received byte, stable while rx_valid=1
//  rx_valid   out  1          holding register full
//  rx_ready   in   1          consumer accepts rx_data when rx_valid & rx_ready
//  frame_err  out  1          1-cycle pulse: stop bit sampled low
//  overrun    out  1          1-cycle pulse: frame completed while holding register full and not drained
// BEHAVIOUR
//  Reset: all synchroniser flops=1, state=IDLE, tick_cnt=0, bit_cnt=0, shift=0, rx_data=0, rx_valid=0,
//   frame_err=0, overrun=0. Reset mid-frame abandons the frame with no output.
//  Counters advance only on cycles with baud_tick=1. Between ticks all state holds.
//  rxd_s = last synchroniser stage. Latency rxd->rxd_s = SYNC_STAGES clk cycles.
//  FSM:
//   IDLE: on tick with rxd_s=0 -> START, tick_cnt=0.
//   START: on tick, tick_cnt++. When tick_cnt reaches OVERSAMPLE/2-1 (mid start bit), sample rxd_s:
//    0 -> DATA, tick_cnt=0, bit_cnt=0. 1 -> false start, IDLE, no output.
//   DATA: on tick, tick_cnt++. When tick_cnt=OVERSAMPLE-1, sample rxd_s into shift MSB, shift right,
//    tick_cnt=0, bit_cnt++. After sampling bit DATA_BITS-1 -> STOP.
//   STOP: after OVERSAMPLE ticks, sample rxd_s:
//    1 -> frame good: deliver (below), -> IDLE.
//    0 -> frame_err=1 for one clk, byte discarded, -> BREAK.
//   BREAK: wait for tick with rxd_s=1 -> IDLE. Line held low (break) yields exactly one frame_err.
//  Delivery (cycle of good stop sample):
//   rx_valid=0, or rx_valid & rx_ready in the same cycle: rx_data<=shift, rx_valid<=1 next cycle.
//   rx_valid=1 & !rx_ready: old byte kept, new byte dropped, overrun=1 for one clk.
//  Handshake: rx_valid & rx_ready with no delivery in that cycle -> rx_valid<=0. rx_ready ignored when
//   rx_valid=0. rx_valid never drops without a handshake.
//  tick_cnt width $clog2(OVERSAMPLE); bit_cnt width $clog2(DATA_BITS+1); all compares exact, no wrap.
//  baud_tick held high continuously is legal (treated as a tick every clk).
// STRUCTURE
//  Package uart_pkg: typedef enum logic[2:0] uart_rx_state_t {IDLE,START,DATA,STOP,BREAK}; frame-format
//   localparams shared with the future uart_tx.
//  Sub-module sync_ff #(STAGES, RESET_VAL): generic bit synchroniser; rxd instanced with RESET_VAL=1.
//  Remainder (FSM, counters, shift register, holding register) flat in uart_rx.
// TESTING
//  Bench: clk 1 MHz, baud_tick every 26 clks (4x 9600), rx_ready=1 unless stated. Reference model
//   drives rxd at exactly 104 clks/bit.
//  1. Send 0x55 then 0xA3 back-to-back -> rx_valid pulses twice, rx_data 0x55 then 0xA3, no errors.
//  2. rxd low for 40 clks then high (glitch < half bit) -> no rx_valid, no frame_err, FSM back in IDLE.
//  3. Send 0x3C with stop bit low, then line high -> one frame_err pulse, rx_valid stays 0; next 0x81 good.
//  4. rx_ready=0; send 0x11, 0x22 -> rx_data=0x11 held, overrun pulses once at 0x22 stop; rx_ready=1 -> 0x11 read.
//  5. rx_valid=1 with 0x11; assert rx_ready exactly in 0x22 stop-sample cycle -> rx_data=0x22, rx_valid stays 1,
//   no overrun.
//  6. Assert rst during bit 4 of 0xF0, release, send 0x0F -> only 0x0F delivered, outputs at reset values
//   during rst.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and the default frame format
// used by both the receiver and the future transmitter.
package uart_pkg;

    localparam int UART_OVERSAMPLE  = 4;
    localparam int UART_DATA_BITS   = 8;
    localparam int UART_STOP_BITS   = 1;
    localparam int UART_SYNC_STAGES = 2;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } uart_rx_state_t;

endpackage

// File: rtl/uart_rx_sync_ff.sv
// Generic single-bit synchroniser chain for bringing an asynchronous input
// into the clock domain; the reset value is chosen to match the line's idle level.
module sync_ff #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic [STAGES-1:0] r_sync;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync <= {STAGES{RESET_VAL}};
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_d};
        end
    end

    assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver: qualifies the start bit at mid-bit, samples data
// LSB first, checks the stop bit and hands bytes out through a one-entry holding register.
module uart_rx
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE  = UART_OVERSAMPLE,
    parameter int DATA_BITS   = UART_DATA_BITS,
    parameter int SYNC_STAGES = UART_SYNC_STAGES
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_baud_tick,
    input  logic                 i_rxd,
    output logic [DATA_BITS-1:0] o_rx_data,
    output logic                 o_rx_valid,
    input  logic                 i_rx_ready,
    output logic                 o_frame_err,
    output logic                 o_overrun
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS + 1);

    localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

    logic                 w_rxd_s;

    uart_rx_state_t       r_state;
    logic [TW-1:0]        r_tick_cnt;
    logic [BW-1:0]        r_bit_cnt;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] r_rx_data;
    logic                 r_rx_valid;
    logic                 r_frame_err;
    logic                 r_overrun;

    uart_rx_state_t       w_state_next;
    logic [TW-1:0]        w_tick_next;
    logic [BW-1:0]        w_bit_next;
    logic [DATA_BITS-1:0] w_shift_next;
    logic [DATA_BITS-1:0] w_rx_data_next;
    logic                 w_rx_valid_next;
    logic                 w_frame_err_next;
    logic                 w_overrun_next;
    logic                 w_stop_good;

    sync_ff #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (1'b1)
    ) u_rxd_sync (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_d   (i_rxd),
        .o_q   (w_rxd_s)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= IDLE;
            r_tick_cnt  <= '0;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_rx_data   <= '0;
            r_rx_valid  <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_tick_cnt  <= w_tick_next;
            r_bit_cnt   <= w_bit_next;
            r_shift     <= w_shift_next;
            r_rx_data   <= w_rx_data_next;
            r_rx_valid  <= w_rx_valid_next;
            r_frame_err <= w_frame_err_next;
            r_overrun   <= w_overrun_next;
        end
    end

    // Frame sequencing; every transition is gated by the baud tick.
    always_comb begin
        w_state_next     = r_state;
        w_tick_next      = r_tick_cnt;
        w_bit_next       = r_bit_cnt;
        w_shift_next     = r_shift;
        w_frame_err_next = 1'b0;
        w_stop_good      = 1'b0;

        if (i_baud_tick) begin
            case (r_state)
                IDLE: begin
                    if (!w_rxd_s) begin
                        w_state_next = START;
                        w_tick_next  = '0;
                    end
                end
                START: begin
                    if (r_tick_cnt == TICK_MID) begin
                        w_state_next = w_rxd_s ? IDLE : DATA;
                        w_tick_next  = '0;
                        w_bit_next   = '0;
                    end else begin
                        w_tick_next = r_tick_cnt + TW'(1);
                    end
                end
                DATA: begin
                    if (r_tick_cnt == TICK_LAST) begin
                        w_shift_next = {w_rxd_s, r_shift[DATA_BITS-1:1]};
                        w_tick_next  = '0;
                        w_bit_next   = r_bit_cnt + BW'(1);
                        if (r_bit_cnt == BIT_LAST) begin
                            w_state_next = STOP;
                        end
                    end else begin
                        w_tick_next = r_tick_cnt + TW'(1);
                    end
                end
                STOP: begin
                    if (r_tick_cnt == TICK_LAST) begin
                        w_tick_next = '0;
                        if (w_rxd_s) begin
                            w_stop_good  = 1'b1;
                            w_state_next = IDLE;
                        end else begin
                            w_frame_err_next = 1'b1;
                            w_state_next     = BREAK;
                        end
                    end else begin
                        w_tick_next = r_tick_cnt + TW'(1);
                    end
                end
                BREAK: begin
                    if (w_rxd_s) begin
                        w_state_next = IDLE;
                    end
                end
                default: begin
                    w_state_next = IDLE;
                end
            endcase
        end
    end

    // A delivery in the same cycle as a handshake replaces the byte, so rx_valid stays high.
    always_comb begin
        w_rx_data_next  = r_rx_data;
        w_rx_valid_next = r_rx_valid;
        w_overrun_next  = 1'b0;

        if (w_stop_good) begin
            if (!r_rx_valid || i_rx_ready) begin
                w_rx_data_next  = r_shift;
                w_rx_valid_next = 1'b1;
            end else begin
                w_overrun_next = 1'b1;
            end
        end else if (r_rx_valid && i_rx_ready) begin
            w_rx_valid_next = 1'b0;
        end
    end

    assign o_rx_data   = r_rx_data;
    assign o_rx_valid  = r_rx_valid;
    assign o_frame_err = r_frame_err;
    assign o_overrun   = r_overrun;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: table-driven frames, hand-written corner
// sequences and randomized traffic compared against a byte-queue reference model.
`timescale 1ns/1ps
module tb_uart_rx;

    localparam int OS            = 4;
    localparam int DB            = 8;
    localparam int CLKS_PER_TICK = 26;
    localparam int CLKS_PER_BIT  = 104;

    typedef struct {
        logic [7:0] data;
        logic       stopBit;
        int         gapBits;
        int         expDeliver;
        int         expFerr;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       baudTick;
    logic       rxd;
    logic       rxReady;
    logic [7:0] rxData;
    logic       rxValid;
    logic       frameErr;
    logic       overrun;

    int checks = 0;
    int errors = 0;
    int cycleNum = 0;

    byte unsigned gotQ[$];
    byte unsigned expQ[$];
    int checkedIdx = 0;
    int ferrCount = 0;
    int ovrCount = 0;
    int protoViol = 0;

    logic       lastValid = 1'b0;
    logic       lastReady = 1'b0;
    logic [7:0] lastData = 8'h00;

    uart_rx #(
        .OVERSAMPLE  (OS),
        .DATA_BITS   (DB),
        .SYNC_STAGES (2)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_baud_tick (baudTick),
        .i_rxd       (rxd),
        .o_rx_data   (rxData),
        .o_rx_valid  (rxValid),
        .i_rx_ready  (rxReady),
        .o_frame_err (frameErr),
        .o_overrun   (overrun)
    );

    always #500 clk = ~clk;

    // Baud strobe: high during every cycle whose number is a multiple of CLKS_PER_TICK.
    initial begin
        baudTick = 1'b0;
        forever begin
            @(posedge clk);
            cycleNum++;
            #100;
            baudTick = ((cycleNum + 1) % CLKS_PER_TICK == 0);
        end
    end

    // Observe outputs mid-cycle: log consumed bytes, count pulses, watch the hold rule.
    always @(negedge clk) begin
        if (rst) begin
            lastValid = 1'b0;
            lastReady = 1'b0;
        end else begin
            if (lastValid && !lastReady && (!rxValid || rxData != lastData))
                protoViol++;
            if (rxValid && rxReady)
                gotQ.push_back(rxData);
            if (frameErr)
                ferrCount++;
            if (overrun)
                ovrCount++;
            lastValid = rxValid;
            lastReady = rxReady;
            lastData  = rxData;
        end
    end

    task automatic stepCycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #100;
        end
    endtask

    task automatic applyStimulus(input logic [7:0] data, input logic stopBit);
        rxd = 1'b0;
        stepCycles(CLKS_PER_BIT);
        for (int i = 0; i < DB; i++) begin
            rxd = data[i];
            stepCycles(CLKS_PER_BIT);
        end
        rxd = stopBit;
        stepCycles(CLKS_PER_BIT);
        rxd = 1'b1;
    endtask

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: actual=%0d (0x%0h) expected=%0d (0x%0h)",
                     name, actual, actual, expected, expected);
        end
    endtask

    task automatic checkBytes(input string name);
        checkOutput({name, " byte count"}, gotQ.size(), expQ.size());
        for (int i = checkedIdx; i < gotQ.size() && i < expQ.size(); i++)
            checkOutput($sformatf("%s byte%0d", name, i), int'(gotQ[i]), int'(expQ[i]));
        checkedIdx = (gotQ.size() > expQ.size()) ? gotQ.size() : expQ.size();
    endtask

    vec_t vecs[7];
    int   ferrBase;
    int   ovrBase;
    int   expFerr;
    int   firstLow;
    int   detectCycle;
    int   stopCycle;

    // Main test sequence.
    initial begin
        vecs[0] = '{8'h3C, 1'b0, 2, 0, 1};
        vecs[1] = '{8'h81, 1'b1, 1, 1, 0};
        vecs[2] = '{8'h00, 1'b1, 1, 1, 0};
        vecs[3] = '{8'hFF, 1'b1, 1, 1, 0};
        vecs[4] = '{8'h80, 1'b1, 1, 1, 0};
        vecs[5] = '{8'h01, 1'b1, 1, 1, 0};
        vecs[6] = '{8'hA5, 1'b0, 2, 0, 1};

        rst = 1'b1;
        rxd = 1'b1;
        rxReady = 1'b1;
        stepCycles(5);
        checkOutput("reset rx_data", int'(rxData), 0);
        checkOutput("reset rx_valid", int'(rxValid), 0);
        checkOutput("reset frame_err", int'(frameErr), 0);
        checkOutput("reset overrun", int'(overrun), 0);
        rst = 1'b0;
        stepCycles(2 * CLKS_PER_BIT);

        $display("[TB] back-to-back 0x55, 0xA3");
        ferrBase = ferrCount;
        ovrBase = ovrCount;
        applyStimulus(8'h55, 1'b1);
        applyStimulus(8'hA3, 1'b1);
        stepCycles(CLKS_PER_BIT);
        expQ.push_back(8'h55);
        expQ.push_back(8'hA3);
        checkBytes("b2b");
        checkOutput("b2b frame_err", ferrCount - ferrBase, 0);
        checkOutput("b2b overrun", ovrCount - ovrBase, 0);

        $display("[TB] short start glitch");
        ferrBase = ferrCount;
        rxd = 1'b0;
        stepCycles(40);
        rxd = 1'b1;
        stepCycles(3 * CLKS_PER_BIT);
        checkBytes("glitch");
        checkOutput("glitch frame_err", ferrCount - ferrBase, 0);
        checkOutput("glitch rx_valid", int'(rxValid), 0);

        $display("[TB] frame table");
        for (int v = 0; v < 7; v++) begin
            ferrBase = ferrCount;
            ovrBase = ovrCount;
            applyStimulus(vecs[v].data, vecs[v].stopBit);
            stepCycles(vecs[v].gapBits * CLKS_PER_BIT + 4);
            if (vecs[v].expDeliver != 0)
                expQ.push_back(vecs[v].data);
            checkBytes($sformatf("vec%0d", v));
            checkOutput($sformatf("vec%0d frame_err", v), ferrCount - ferrBase, vecs[v].expFerr);
            checkOutput($sformatf("vec%0d overrun", v), ovrCount - ovrBase, 0);
        end

        $display("[TB] held break");
        ferrBase = ferrCount;
        rxd = 1'b0;
        stepCycles(20 * CLKS_PER_BIT);
        rxd = 1'b1;
        stepCycles(2 * CLKS_PER_BIT);
        checkBytes("break");
        checkOutput("break frame_err", ferrCount - ferrBase, 1);

        $display("[TB] overrun with consumer stalled");
        rxReady = 1'b0;
        ovrBase = ovrCount;
        stepCycles(2);
        applyStimulus(8'h11, 1'b1);
        applyStimulus(8'h22, 1'b1);
        stepCycles(CLKS_PER_BIT);
        checkOutput("stall rx_valid", int'(rxValid), 1);
        checkOutput("stall rx_data", int'(rxData), 8'h11);
        checkOutput("stall overrun", ovrCount - ovrBase, 1);
        checkBytes("stall");
        rxReady = 1'b1;
        stepCycles(1);
        rxReady = 1'b0;
        stepCycles(2);
        expQ.push_back(8'h11);
        checkBytes("drain");
        checkOutput("drain rx_valid", int'(rxValid), 0);

        $display("[TB] ready coincident with stop sample");
        ovrBase = ovrCount;
        applyStimulus(8'h11, 1'b1);
        stepCycles(20);
        checkOutput("coinc pre rx_valid", int'(rxValid), 1);
        checkOutput("coinc pre rx_data", int'(rxData), 8'h11);
        firstLow = cycleNum + 1;
        detectCycle = ((firstLow + 2 + CLKS_PER_TICK - 1) / CLKS_PER_TICK) * CLKS_PER_TICK;
        stopCycle = detectCycle + (OS / 2 + OS * (DB + 1)) * CLKS_PER_TICK;
        fork
            applyStimulus(8'h22, 1'b1);
            begin
                stepCycles(stopCycle - 1 - cycleNum);
                rxReady = 1'b1;
                stepCycles(1);
                rxReady = 1'b0;
            end
        join
        stepCycles(20);
        checkOutput("coinc rx_data", int'(rxData), 8'h22);
        checkOutput("coinc rx_valid", int'(rxValid), 1);
        checkOutput("coinc overrun", ovrCount - ovrBase, 0);
        expQ.push_back(8'h11);
        checkBytes("coinc");
        rxReady = 1'b1;
        stepCycles(2);
        expQ.push_back(8'h22);
        checkBytes("coinc drain");

        $display("[TB] reset mid-frame");
        fork
            applyStimulus(8'hF0, 1'b1);
            begin
                stepCycles(5 * CLKS_PER_BIT + CLKS_PER_BIT / 2);
                rst = 1'b1;
                stepCycles(3);
                checkOutput("midrst rx_data", int'(rxData), 0);
                checkOutput("midrst rx_valid", int'(rxValid), 0);
                checkOutput("midrst frame_err", int'(frameErr), 0);
                checkOutput("midrst overrun", int'(overrun), 0);
                stepCycles(5);
                rst = 1'b0;
            end
        join
        stepCycles(2 * CLKS_PER_BIT);
        applyStimulus(8'h0F, 1'b1);
        stepCycles(CLKS_PER_BIT);
        expQ.push_back(8'h0F);
        checkBytes("after reset");

        $display("[TB] random traffic");
        ferrBase = ferrCount;
        ovrBase = ovrCount;
        expFerr = 0;
        for (int n = 0; n < 24; n++) begin
            logic [7:0] d;
            logic       good;
            int         gap;
            d = 8'($urandom_range(0, 255));
            good = ($urandom_range(0, 7) != 0);
            gap = good ? int'($urandom_range(0, 2)) : int'($urandom_range(1, 2));
            applyStimulus(d, good);
            stepCycles(gap * CLKS_PER_BIT);
            if (good)
                expQ.push_back(d);
            else
                expFerr++;
        end
        stepCycles(2 * CLKS_PER_BIT);
        checkBytes("random");
        checkOutput("random frame_err", ferrCount - ferrBase, expFerr);
        checkOutput("random overrun", ovrCount - ovrBase, 0);
        checkOutput("handshake hold rule", protoViol, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
